cam_pixel_capture: RTL

Capture stage between the OV7670 parallel pixel bus and the frame buffer write port. It oversamples `pclk_i`, `href_i`, `vsync_i` and `data_i` in the system clock domain and frames them into whole pictures. It pairs bytes into RGB444 pixels and emits one linear-address write per pixel. It replaces the ad-hoc write path into port A of `frame_buffer` and provides frame and error status for debug LEDs.

---
 rtl/cam_pixel_capture.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cam_pixel_capture.sv
// rtl/cam_pixel_capture.sv - OV7670 byte-pair capture into linear RGB444 frame buffer writes
module cam_pixel_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              pclk_i,
    input  logic              vsync_i,
    input  logic              href_i,
    input  logic [7:0]        data_i,
    output logic              fb_wr_o,
    output logic [ADDR_W-1:0] fb_addr_o,
    output logic [11:0]       fb_data_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              overflow_o,
    output logic              line_err_o
);

    localparam int NPIX = H_ACTIVE * V_ACTIVE;
    localparam int LCW  = $clog2(H_ACTIVE + 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NPIX - 1);
    localparam logic [LCW-1:0]    LINE_FULL = LCW'(H_ACTIVE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VS,
        S_VBLANK,
        S_ACTIVE
    } state_t;

    state_t state;

    logic       pclk_m, pclk_s, pclk_d;
    logic       vsync_m, vsync_s, vsync_d;
    logic       href_m, href_s, href_d;
    logic [7:0] data_m, data_s, data_d;
    logic       byte_evt;

    logic              pclk_rise, vs_rise, vs_fall, href_fall;
    logic [ADDR_W-1:0] addr;
    logic              full;
    logic              phase;
    logic [3:0]        red;
    logic [LCW-1:0]    line_cnt;

    assign pclk_rise = pclk_s & ~pclk_d;
    assign vs_rise   = vsync_s & ~vsync_d;
    assign vs_fall   = ~vsync_s & vsync_d;
    assign href_fall = href_d & ~href_s;
    assign busy_o    = (state != S_IDLE);

    // Two-flop synchronisers plus a delayed copy for edge detection.
    // byte_evt is the registered byte strobe; it lines up with data_d,
    // which is data_s one cycle later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pclk_m   <= 1'b0;
            pclk_s   <= 1'b0;
            pclk_d   <= 1'b0;
            vsync_m  <= 1'b0;
            vsync_s  <= 1'b0;
            vsync_d  <= 1'b0;
            href_m   <= 1'b0;
            href_s   <= 1'b0;
            href_d   <= 1'b0;
            data_m   <= 8'h00;
            data_s   <= 8'h00;
            data_d   <= 8'h00;
            byte_evt <= 1'b0;
        end else begin
            pclk_m   <= pclk_i;
            pclk_s   <= pclk_m;
            pclk_d   <= pclk_s;
            vsync_m  <= vsync_i;
            vsync_s  <= vsync_m;
            vsync_d  <= vsync_s;
            href_m   <= href_i;
            href_s   <= href_m;
            href_d   <= href_s;
            data_m   <= data_i;
            data_s   <= data_m;
            data_d   <= data_s;
            byte_evt <= pclk_rise & href_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            fb_wr_o      <= 1'b0;
            fb_addr_o    <= '0;
            fb_data_o    <= 12'h000;
            frame_done_o <= 1'b0;
            overflow_o   <= 1'b0;
            line_err_o   <= 1'b0;
            addr         <= '0;
            full         <= 1'b0;
            phase        <= 1'b0;
            red          <= 4'h0;
            line_cnt     <= '0;
        end else begin
            fb_wr_o      <= 1'b0;
            frame_done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) state <= S_WAIT_VS;
                end
                S_WAIT_VS: begin
                    if (!start_i)     state <= S_IDLE;
                    else if (vs_rise) state <= S_VBLANK;
                end
                S_VBLANK: begin
                    if (vs_fall) begin
                        state      <= S_ACTIVE;
                        addr       <= '0;
                        full       <= 1'b0;
                        phase      <= 1'b0;
                        line_cnt   <= '0;
                        overflow_o <= 1'b0;
                        line_err_o <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (vs_rise) begin
                        // Frame end takes priority; a byte arriving now is dropped
                        // and a half-formed pixel counts as a broken line.
                        frame_done_o <= 1'b1;
                        if (phase) line_err_o <= 1'b1;
                        phase <= 1'b0;
                        state <= start_i ? S_VBLANK : S_IDLE;
                    end else begin
                        if (byte_evt) begin
                            if (!phase) begin
                                red   <= data_d[3:0];
                                phase <= 1'b1;
                            end else begin
                                phase <= 1'b0;
                                if (line_cnt != LINE_FULL + LCW'(1)) line_cnt <= line_cnt + LCW'(1);
                                if (full) begin
                                    overflow_o <= 1'b1;
                                end else begin
                                    fb_wr_o   <= 1'b1;
                                    fb_addr_o <= addr;
                                    fb_data_o <= {red, data_d};
                                    // Address parks on the last slot once the frame is full.
                                    if (addr == ADDR_LAST) full <= 1'b1;
                                    else                   addr <= addr + ADDR_W'(1);
                                end
                            end
                        end
                        if (href_fall) begin
                            if (phase || (line_cnt != LINE_FULL)) line_err_o <= 1'b1;
                            phase    <= 1'b0;
                            line_cnt <= '0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
